brq_ifu_dummy_reseed: RTL and testbench
=======================================

BRQ_IFU_DUMMY_RESEED -- requirements
Module: brq_ifu_dummy_reseed

Interface
REQ-001 SHALL have parameter ReseedCount, default 64: dummy insertions between automatic reseeds (range 1..65535).
REQ-002 SHALL have parameter AckTimeout, default 255: maximum cycles in REQ awaiting edn_ack_i (range 1..65535).
REQ-003 SHALL have one clock; reset is asynchronous and active-high. Ports clk_i (in, 1) then rst_i (in, 1, async active-high).
REQ-004 dummy_instr_en_i  in  1  dummy-instruction feature enabled (CSR).
REQ-005 reseed_req_i  in  1  single-cycle software reseed request (CSR write strobe).
REQ-006 dummy_insert_i  in  1  one dummy instruction consumed this cycle (insert & id_in_ready).
REQ-007 edn_req_o  out  1  entropy request.
REQ-008 edn_ack_i  in  1  entropy valid; edn_data_i  in  32  entropy word.
REQ-009 seed_en_o  out  1  one-cycle seed load strobe to dummy generator.
REQ-010 seed_o  out  32  seed value, meaningful when seed_en_o=1.
REQ-011 dummy_hold_o  out  1  suppress dummy insertion while reseeding.
REQ-012 reseed_busy_o  out  1  FSM not IDLE.
REQ-013 reseed_err_o  out  1  sticky: last reseed attempt timed out.
REQ-014 reseed_cnt_o  out  8  successful reseeds, saturating at 255.

Function
REQ-015 FSM states IDLE, REQ, LOAD; registered state, one transition per cycle max.
REQ-016 IDLE: 16-bit insertion counter increments on dummy_insert_i while dummy_instr_en_i=1; held when disabled.
REQ-017 IDLE -> REQ when dummy_instr_en_i=1 and (reseed_req_i=1, pending flag set, or dummy_insert_i=1 with counter = ReseedCount-1); counter clears on this transition.
REQ-018 reseed_req_i in IDLE with dummy_instr_en_i=0 is dropped.
REQ-019 reseed_req_i in REQ or LOAD sets one pending flag (further requests merge); flag clears on next IDLE -> REQ.
REQ-020 REQ: edn_req_o=1 every cycle; 16-bit timeout counter starts at 0 on entry, increments each cycle.
REQ-021 REQ, edn_ack_i=1: capture edn_data_i into seed register, -> LOAD; ack wins over simultaneous timeout.
REQ-022 Zero entropy word SHALL be replaced by 32'h0000_0001 in the seed register.
REQ-023 REQ, no ack and timeout counter = AckTimeout-1: -> IDLE, set reseed_err_o, edn_req_o low next cycle.
REQ-024 LOAD: seed_en_o=1 and seed_o=captured seed for exactly one cycle; reseed_err_o cleared; reseed_cnt_o increments (saturating); -> IDLE.
REQ-025 dummy_hold_o=1 and reseed_busy_o=1 in REQ and LOAD, 0 in IDLE; all outputs registered or decoded from registered state only.
REQ-026 seed_o SHALL be 0 whenever seed_en_o=0.
REQ-027 edn_ack_i outside REQ (late ack after timeout) SHALL be ignored.
REQ-028 dummy_instr_en_i falling during REQ/LOAD SHALL NOT abort the sequence.
REQ-029 dummy_insert_i outside IDLE SHALL NOT be counted.
REQ-030 Latency: reseed_req_i in IDLE -> edn_req_o high next cycle; ack -> seed_en_o next cycle.

Reset
REQ-031 rst_i=1 asynchronously forces IDLE, clears both counters, pending flag, seed register; all outputs 0, including mid-handshake (edn_req_o drops immediately).
REQ-032 Operation resumes on the first clk_i edge after rst_i deasserts.

Structure
REQ-033 State enum dummy_reseed_state_e and the zero-seed substitute constant SHALL live in brq_pkg.
REQ-034 No sub-module; counters and FSM inline.

Verification
REQ-035 ReseedCount=4, en=1, 4 dummy_insert_i pulses, ack 3 cycles after req with 32'hA5A5_0F0F -> one seed_en_o pulse, seed_o=32'hA5A5_0F0F, reseed_cnt_o=1, hold high 4 cycles.
REQ-036 reseed_req_i in IDLE, edn_data_i=0 at ack -> seed_o=32'h0000_0001.
REQ-037 AckTimeout=8, no ack -> edn_req_o high exactly 8 cycles, reseed_err_o=1, no seed_en_o; next successful reseed clears err.
REQ-038 reseed_req_i twice during REQ -> exactly two reseed sequences total, back-to-back (one IDLE cycle between).
REQ-039 rst_i asserted in REQ -> edn_req_o, hold, busy 0 same cycle; ack after reset ignored.
REQ-040 256 successful reseeds -> reseed_cnt_o saturates at 255.

Source files
------------

// File: rtl/brq_pkg.sv
// Shared types and constants for the instruction-fetch dummy-reseed logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: reseed FSM state encoding and the substitute seed used when the
// entropy source returns an all-zero word.
package brq_pkg;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_LOAD = 2'd2
    } dummy_reseed_state_e;

    // An all-zero seed would lock an LFSR-style dummy generator, so it is
    // replaced by this value before it is loaded.
    localparam logic [31:0] DUMMY_ZERO_SEED_SUB = 32'h0000_0001;

endpackage

// File: rtl/brq_ifu_dummy_reseed.sv
// Reseeds the dummy-instruction generator from EDN, automatically every
// ReseedCount insertions or on a software request.
// Latency: trigger -> edn_req_o next cycle; edn_ack_i -> seed_en_o next cycle.
// Backpressure: EDN handshake is req/ack with an AckTimeout-cycle limit;
// dummy_hold_o stalls dummy insertion while a reseed is in flight.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   dummy_instr_en_i     dummy-instruction feature enable (CSR)
//   reseed_req_i         one-cycle software reseed strobe
//   dummy_insert_i       one dummy instruction consumed this cycle
//   edn_req_o/edn_ack_i  entropy request / entropy valid
//   edn_data_i           32-bit entropy word
//   seed_en_o, seed_o    one-cycle seed load strobe and seed value
//   dummy_hold_o         suppress dummy insertion while reseeding
//   reseed_busy_o        FSM not idle
//   reseed_err_o         sticky: last reseed attempt timed out
//   reseed_cnt_o         successful reseeds, saturating at 255
module brq_ifu_dummy_reseed
    import brq_pkg::*;
#(
    parameter int unsigned ReseedCount = 64,
    parameter int unsigned AckTimeout  = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dummy_instr_en_i,
    input  logic        reseed_req_i,
    input  logic        dummy_insert_i,
    output logic        edn_req_o,
    input  logic        edn_ack_i,
    input  logic [31:0] edn_data_i,
    output logic        seed_en_o,
    output logic [31:0] seed_o,
    output logic        dummy_hold_o,
    output logic        reseed_busy_o,
    output logic        reseed_err_o,
    output logic [7:0]  reseed_cnt_o
);

    localparam logic [15:0] InsLast = 16'(ReseedCount - 1);
    localparam logic [15:0] TmoLast = 16'(AckTimeout - 1);

    dummy_reseed_state_e state_q, state_d;
    logic [15:0] ins_cnt_q, ins_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] seed_q, seed_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        start;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= DR_IDLE;
            ins_cnt_q <= '0;
            tmo_cnt_q <= '0;
            pend_q    <= 1'b0;
            seed_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ins_cnt_q <= ins_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            pend_q    <= pend_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ins_cnt_d = ins_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        pend_d    = pend_q;
        seed_d    = seed_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        start     = 1'b0;

        case (state_q)
            DR_IDLE: begin
                // A software request with the feature disabled is simply
                // dropped; a merged pending request waits for enable.
                start = dummy_instr_en_i &
                        (reseed_req_i | pend_q |
                         (dummy_insert_i & (ins_cnt_q == InsLast)));
                if (start) begin
                    state_d   = DR_REQ;
                    ins_cnt_d = '0;
                    tmo_cnt_d = '0;
                    pend_d    = 1'b0;
                end else if (dummy_instr_en_i && dummy_insert_i) begin
                    ins_cnt_d = ins_cnt_q + 16'd1;
                end
            end
            DR_REQ: begin
                if (reseed_req_i) begin
                    pend_d = 1'b1;
                end
                // Ack takes priority over a coincident timeout.
                if (edn_ack_i) begin
                    seed_d  = (edn_data_i == '0) ? DUMMY_ZERO_SEED_SUB : edn_data_i;
                    state_d = DR_LOAD;
                end else if (tmo_cnt_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = DR_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            DR_LOAD: begin
                if (reseed_req_i) begin
                    pend_d = 1'b1;
                end
                err_d = 1'b0;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                state_d = DR_IDLE;
            end
            default: begin
                state_d = DR_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so reset removes them at once.
    assign edn_req_o     = (state_q == DR_REQ);
    assign seed_en_o     = (state_q == DR_LOAD);
    assign seed_o        = (state_q == DR_LOAD) ? seed_q : '0;
    assign dummy_hold_o  = (state_q != DR_IDLE);
    assign reseed_busy_o = (state_q != DR_IDLE);
    assign reseed_err_o  = err_q;
    assign reseed_cnt_o  = cnt_q;

endmodule

// File: tb/tb_brq_ifu_dummy_reseed.sv
module tb_brq_ifu_dummy_reseed;

    localparam int RC = 4;
    localparam int AT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dummy_instr_en_i;
    logic        reseed_req_i;
    logic        dummy_insert_i;
    logic        edn_req_o;
    logic        edn_ack_i;
    logic [31:0] edn_data_i;
    logic        seed_en_o;
    logic [31:0] seed_o;
    logic        dummy_hold_o;
    logic        reseed_busy_o;
    logic        reseed_err_o;
    logic [7:0]  reseed_cnt_o;

    int checks = 0;
    int errors = 0;
    int ins_model = 0;  // insertions seen since the last reseed start
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    brq_ifu_dummy_reseed #(.ReseedCount(RC), .AckTimeout(AT)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dummy_instr_en_i (dummy_instr_en_i),
        .reseed_req_i     (reseed_req_i),
        .dummy_insert_i   (dummy_insert_i),
        .edn_req_o        (edn_req_o),
        .edn_ack_i        (edn_ack_i),
        .edn_data_i       (edn_data_i),
        .seed_en_o        (seed_en_o),
        .seed_o           (seed_o),
        .dummy_hold_o     (dummy_hold_o),
        .reseed_busy_o    (reseed_busy_o),
        .reseed_err_o     (reseed_err_o),
        .reseed_cnt_o     (reseed_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Start a reseed by software strobe; edn_req_o must follow next cycle.
    task automatic trigger_sw(input string nm);
        dummy_instr_en_i = 1'b1;
        dummy_insert_i   = 1'b0;
        reseed_req_i     = 1'b1;
        tick();
        reseed_req_i = 1'b0;
        ins_model    = 0;
        checks++;
        if (edn_req_o !== 1'b1) begin
            errors++;
            $display("FAIL %s sw trigger latency: edn_req_o=%b want 1", nm, edn_req_o);
        end
    endtask

    // Run one handshake from the first REQ cycle. Ack is given in REQ cycle k
    // (0-based); k >= AT means no ack. sw_pulses strobes reseed_req_i in the
    // first REQ cycles. Enable and insert toggle randomly throughout.
    task automatic do_handshake(input int k, input logic [31:0] data,
                                input int sw_pulses, input string nm);
        int req_n = 0;
        int hold_n = 0;
        int en_n = 0;
        int cyc = 0;
        int seed_bad = 0;
        logic [31:0] seen = 32'h0;
        logic [31:0] exp_seed;
        bit acked;
        int exp_req;
        acked    = (k < AT);
        exp_req  = acked ? k + 1 : AT;
        exp_seed = (data == 32'h0) ? 32'h1 : data;
        while (reseed_busy_o && cyc < 40) begin
            if (edn_req_o) req_n++;
            if (dummy_hold_o) hold_n++;
            if (seed_en_o) begin
                en_n++;
                seen = seed_o;
            end else if (seed_o !== 32'h0) begin
                seed_bad++;
            end
            edn_ack_i        = edn_req_o && (req_n - 1 == k);
            edn_data_i       = edn_ack_i ? data : $urandom;
            reseed_req_i     = edn_req_o && (req_n - 1 < sw_pulses);
            dummy_insert_i   = 1'($urandom % 2);
            dummy_instr_en_i = 1'($urandom % 2);
            tick();
            cyc++;
        end
        edn_ack_i        = 1'b0;
        reseed_req_i     = 1'b0;
        dummy_insert_i   = 1'b0;
        dummy_instr_en_i = 1'b1;
        if (acked) begin
            exp_err = 1'b0;
            if (exp_cnt < 255) exp_cnt++;
        end else begin
            exp_err = 1'b1;
        end
        checks++;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL %s stuck busy: cycles=%0d limit 40", nm, cyc);
        end
        checks++;
        if (req_n != exp_req) begin
            errors++;
            $display("FAIL %s edn_req cycles: got %0d want %0d", nm, req_n, exp_req);
        end
        checks++;
        if (hold_n != exp_req + int'(acked)) begin
            errors++;
            $display("FAIL %s hold cycles: got %0d want %0d", nm, hold_n, exp_req + int'(acked));
        end
        checks++;
        if (en_n != int'(acked)) begin
            errors++;
            $display("FAIL %s seed_en pulses: got %0d want %0d", nm, en_n, int'(acked));
        end
        if (acked) begin
            checks++;
            if (seen !== exp_seed) begin
                errors++;
                $display("FAIL %s seed_o: got %h want %h", nm, seen, exp_seed);
            end
        end
        checks++;
        if (seed_bad != 0) begin
            errors++;
            $display("FAIL %s seed_o nonzero without seed_en: got %0d cycles want 0", nm, seed_bad);
        end
        checks++;
        if (reseed_err_o !== exp_err) begin
            errors++;
            $display("FAIL %s reseed_err_o: got %b want %b", nm, reseed_err_o, exp_err);
        end
        checks++;
        if (reseed_cnt_o !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL %s reseed_cnt_o: got %0d want %0d", nm, reseed_cnt_o, exp_cnt);
        end
    endtask

    // Random enable/insert traffic in IDLE until the model predicts the
    // automatic reseed; disabled-state software requests must be dropped.
    task automatic trigger_ins(input string nm);
        bit en_r, ins_r, rq, fire;
        for (int i = 0; i < 300; i++) begin
            en_r  = ($urandom % 4) != 0;
            ins_r = 1'($urandom % 2);
            rq    = !en_r && ($urandom % 2 == 1);
            fire  = en_r && ins_r && (ins_model == RC - 1);
            dummy_instr_en_i = en_r;
            dummy_insert_i   = ins_r;
            reseed_req_i     = rq;
            tick();
            checks++;
            if (edn_req_o !== fire) begin
                errors++;
                $display("FAIL %s auto trigger: edn_req_o=%b want %b count=%0d", nm, edn_req_o, fire, ins_model);
            end
            if (fire) begin
                ins_model = 0;
                break;
            end else if (en_r && ins_r) begin
                ins_model++;
            end
        end
        dummy_insert_i   = 1'b0;
        reseed_req_i     = 1'b0;
        dummy_instr_en_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        dummy_instr_en_i = 1'b0;
        reseed_req_i = 1'b0;
        dummy_insert_i = 1'b0;
        edn_ack_i = 1'b0;
        edn_data_i = 32'h0;
        tick();
        tick();
        checks++;
        if ({edn_req_o, seed_en_o, dummy_hold_o, reseed_busy_o, reseed_err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset flags: got %b want 00000",
                     {edn_req_o, seed_en_o, dummy_hold_o, reseed_busy_o, reseed_err_o});
        end
        checks++;
        if (seed_o !== 32'h0 || reseed_cnt_o !== 8'h0) begin
            errors++;
            $display("FAIL reset values: seed_o=%h cnt=%0d want 0 0", seed_o, reseed_cnt_o);
        end
        #2 rst_i = 1'b0;
        tick();
        exp_cnt = 0;
        exp_err = 1'b0;
        ins_model = 0;
    endtask

    task automatic test_auto_reseed();
        dummy_instr_en_i = 1'b1;
        for (int i = 0; i < RC; i++) begin
            dummy_insert_i = 1'b1;
            tick();
            if (i == RC - 2) begin
                checks++;
                if (edn_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL auto early: edn_req_o=%b want 0", edn_req_o);
                end
            end
        end
        dummy_insert_i = 1'b0;
        ins_model = 0;
        checks++;
        if (edn_req_o !== 1'b1) begin
            errors++;
            $display("FAIL auto start: edn_req_o=%b want 1", edn_req_o);
        end
        do_handshake(2, 32'hA5A5_0F0F, 0, "auto");
    endtask

    task automatic test_zero_seed();
        trigger_sw("zero");
        do_handshake(int'($urandom_range(0, 5)), 32'h0, 0, "zero");
    endtask

    task automatic test_timeout();
        trigger_sw("tmo");
        do_handshake(100, $urandom, 0, "tmo");
        // A late ack in IDLE must be ignored.
        edn_ack_i  = 1'b1;
        edn_data_i = $urandom;
        tick();
        tick();
        edn_ack_i = 1'b0;
        checks++;
        if (reseed_busy_o !== 1'b0 || seed_en_o !== 1'b0 || reseed_err_o !== 1'b1) begin
            errors++;
            $display("FAIL late ack: busy=%b seed_en=%b err=%b want 0 0 1",
                     reseed_busy_o, seed_en_o, reseed_err_o);
        end
        trigger_sw("tmo_recover");
        do_handshake(1, $urandom, 0, "tmo_recover");
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        trigger_sw("b2b");
        do_handshake(3, $urandom, 2, "b2b_first");
        checks++;
        if (reseed_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b gap: busy=%b want 0", reseed_busy_o);
        end
        tick();
        ins_model = 0;
        checks++;
        if (edn_req_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b second start: edn_req_o=%b want 1", edn_req_o);
        end
        do_handshake(1, $urandom, 0, "b2b_second");
        for (int i = 0; i < 6; i++) begin
            tick();
            if (reseed_busy_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b third sequence: busy cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            if ($urandom % 2 == 1) trigger_sw("rand_sw");
            else trigger_ins("rand_ins");
            do_handshake(int'($urandom_range(0, 10)),
                         ($urandom % 4 == 0) ? 32'h0 : $urandom, 0, "rand");
        end
    endtask

    task automatic test_reset_mid_req();
        trigger_sw("rst_mid");
        tick();
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({edn_req_o, dummy_hold_o, reseed_busy_o, reseed_err_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset mid req: req/hold/busy/err=%b want 0000",
                     {edn_req_o, dummy_hold_o, reseed_busy_o, reseed_err_o});
        end
        #3 rst_i = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        ins_model = 0;
        dummy_instr_en_i = 1'b1;
        edn_ack_i  = 1'b1;
        edn_data_i = $urandom;
        tick();
        tick();
        tick();
        edn_ack_i = 1'b0;
        checks++;
        if (reseed_busy_o !== 1'b0 || seed_en_o !== 1'b0 || reseed_cnt_o !== 8'h0) begin
            errors++;
            $display("FAIL ack after reset: busy=%b seed_en=%b cnt=%0d want 0 0 0",
                     reseed_busy_o, seed_en_o, reseed_cnt_o);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 257; n++) begin
            trigger_sw("sat");
            do_handshake(0, $urandom | 32'h1, 0, "sat");
        end
        checks++;
        if (reseed_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL saturation: reseed_cnt_o=%0d want 255", reseed_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_auto_reseed();
        test_zero_seed();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_req();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
